// File: rtl/zx_dma_master_if.sv
// Z80 bus signals shared by zx_dma_master (initiator) and the bus side it drives.
// Handshake: n_busrq low requests the bus, n_busack low grants it, and strobes are driven only while granted.
interface zx_dma_master_if;
   logic        n_busrq;
   logic        n_busack;
   logic [15:0] a;
   logic        a_oe;
   logic [7:0]  d_o;
   logic        d_oe;
   logic [7:0]  d_i;
   logic        n_mreq;
   logic        n_iorq;
   logic        n_rd;
   logic        n_wr;

   modport master (
      output n_busrq, a, a_oe, d_o, d_oe, n_mreq, n_iorq, n_rd, n_wr,
      input  n_busack, d_i
   );

   modport slave (
      input  n_busrq, a, a_oe, d_o, d_oe, n_mreq, n_iorq, n_rd, n_wr,
      output n_busack, d_i
   );
endinterface

// File: rtl/zx_dma_master.sv
// Z80-bus DMA initiator: acquires the bus, then copies LEN bytes SRC->DST with Z80-timed read/write cycles.
// Define ZX_DMA_BYTEMODE_EN to add byte mode (MODE b4): the bus is released between bytes.
module zx_dma_master #(
   parameter int RELEASE_GAP = 4
) (
   input  logic            clk28,
   input  logic            rst_n,
   input  logic            clkcpu_rise,
   input  logic            cfg_wr,
   input  logic [2:0]      cfg_addr,
   input  logic [7:0]      cfg_d,
   output logic [7:0]      cfg_q,
   zx_dma_master_if.master bus,
   output logic            busy,
   output logic            irq,
   output logic [3:0]      state_dbg
);

   // The NEXT step (counter update, loop/release decision) is folded into the edge leaving WR3,
   // so one byte costs exactly six T-states.
   typedef enum logic [3:0] {
      S_IDLE, S_REQ, S_RD1, S_RD2, S_RD3, S_WR1, S_WR2, S_WR3, S_REL, S_GAP
   } state_t;

   state_t      state, state_nx;
   logic [15:0] src, dst, len;
   logic [4:0]  mode;
   logic [7:0]  data_q;
   logic [7:0]  gap_cnt;
   logic        stop_pend;
   logic        in_cycle, start_req, abort_req, stop_now, normal_end;
   logic        byte_mode, mode_b4_d;

   assign start_req = cfg_wr && (cfg_addr == 3'd7) && cfg_d[0] && !cfg_d[1];
   assign abort_req = cfg_wr && (cfg_addr == 3'd7) && cfg_d[1];
   assign in_cycle  = (state inside {S_RD1, S_RD2, S_RD3, S_WR1, S_WR2, S_WR3});
   assign busy      = (state != S_IDLE) && (state != S_REL);
   // Abort, or the grant vanishing mid-transfer, lets the current cycle finish then releases.
   assign stop_now  = stop_pend || abort_req || bus.n_busack;
   assign state_dbg = state;

`ifdef ZX_DMA_BYTEMODE_EN
   assign byte_mode = mode[4];
   assign mode_b4_d = cfg_d[4];
`else
   assign byte_mode = 1'b0;
   assign mode_b4_d = 1'b0;
`endif

   always_comb begin
      state_nx   = state;
      normal_end = 1'b0;
      case (state)
         S_IDLE: if (start_req) state_nx = S_REQ;
         S_REL: begin
            if (start_req)        state_nx = S_REQ;
            else if (clkcpu_rise) state_nx = S_IDLE;
         end
         S_REQ: begin
            if (abort_req)                          state_nx = S_REL;
            else if (clkcpu_rise && !bus.n_busack) state_nx = S_RD1;
         end
         S_GAP: begin
            if (abort_req)                           state_nx = S_REL;
            else if (clkcpu_rise && gap_cnt == 8'd0) state_nx = S_REQ;
         end
         S_RD1: if (clkcpu_rise) state_nx = S_RD2;
         S_RD2: if (clkcpu_rise) state_nx = S_RD3;
         S_RD3: if (clkcpu_rise) state_nx = stop_now ? S_REL : S_WR1;
         S_WR1: if (clkcpu_rise) state_nx = S_WR2;
         S_WR2: if (clkcpu_rise) state_nx = S_WR3;
         S_WR3: begin
            if (clkcpu_rise) begin
               if (stop_now) begin
                  state_nx = S_REL;
               end else if (len == 16'd1) begin
                  state_nx   = S_REL;
                  normal_end = 1'b1;
               end else if (byte_mode) begin
                  state_nx = S_GAP;
               end else begin
                  state_nx = S_RD1;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         src       <= 16'h0000;
         dst       <= 16'h0000;
         len       <= 16'h0000;
         mode      <= 5'd0;
         data_q    <= 8'h00;
         gap_cnt   <= 8'd0;
         stop_pend <= 1'b0;
         irq       <= 1'b0;
      end else begin
         state <= state_nx;
         irq   <= normal_end;
         if (state_nx == S_REL)
            stop_pend <= 1'b0;
         else if (in_cycle && (abort_req || (clkcpu_rise && bus.n_busack)))
            stop_pend <= 1'b1;
         if (state == S_RD3 && clkcpu_rise)
            data_q <= bus.d_i;
         if (state_nx == S_GAP && state != S_GAP)
            gap_cnt <= 8'(RELEASE_GAP - 1);
         else if (state == S_GAP && clkcpu_rise && gap_cnt != 8'd0)
            gap_cnt <= gap_cnt - 8'd1;
         if (state == S_WR3 && clkcpu_rise) begin
            if (!mode[2]) src <= src + 16'd1;
            if (!mode[3]) dst <= dst + 16'd1;
            len <= len - 16'd1;
         end else if (cfg_wr && !busy) begin
            case (cfg_addr)
               3'd0:    src[7:0]  <= cfg_d;
               3'd1:    src[15:8] <= cfg_d;
               3'd2:    dst[7:0]  <= cfg_d;
               3'd3:    dst[15:8] <= cfg_d;
               3'd4:    len[7:0]  <= cfg_d;
               3'd5:    len[15:8] <= cfg_d;
               3'd6:    mode      <= {mode_b4_d, cfg_d[3:0]};
               default: ;
            endcase
         end
      end
   end

   // Bus pins are decoded from the registered state so they change only at T-state edges.
   always_comb begin
      bus.n_busrq = 1'b1;
      bus.a_oe    = 1'b0;
      bus.a       = 16'h0000;
      bus.d_oe    = 1'b0;
      bus.n_mreq  = 1'b1;
      bus.n_iorq  = 1'b1;
      bus.n_rd    = 1'b1;
      bus.n_wr    = 1'b1;
      case (state)
         S_REQ: bus.n_busrq = 1'b0;
         S_RD1, S_RD2, S_RD3: begin
            bus.n_busrq = 1'b0;
            bus.a_oe    = 1'b1;
            bus.a       = src;
            if (!mode[0]) begin
               bus.n_mreq = 1'b0;
               bus.n_rd   = 1'b0;
            end else if (state != S_RD1) begin
               bus.n_iorq = 1'b0;
               bus.n_rd   = 1'b0;
            end
         end
         S_WR1, S_WR2, S_WR3: begin
            bus.n_busrq = 1'b0;
            bus.a_oe    = 1'b1;
            bus.a       = dst;
            bus.d_oe    = 1'b1;
            if (state != S_WR1) bus.n_wr = 1'b0;
            if (!mode[1])              bus.n_mreq = 1'b0;
            else if (state != S_WR1)   bus.n_iorq = 1'b0;
         end
         default: ;
      endcase
   end

   assign bus.d_o = data_q;

   always_comb begin
      cfg_q = 8'h00;
      case (cfg_addr)
         3'd0: cfg_q = src[7:0];
         3'd1: cfg_q = src[15:8];
         3'd2: cfg_q = dst[7:0];
         3'd3: cfg_q = dst[15:8];
         3'd4: cfg_q = len[7:0];
         3'd5: cfg_q = len[15:8];
         3'd6: cfg_q = {3'b000, mode};
         3'd7: cfg_q = {7'b0000000, busy};
         default: cfg_q = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_zx_dma_master.sv
// Bench for zx_dma_master: memory/IO bus responder with programmable grant delay, a T-state monitor,
// and a transfer-level reference model feeding expected read/write queues.
`timescale 1ns/1ps
module tb_zx_dma_master;

`ifdef ZX_DMA_BYTEMODE_EN
   localparam bit BM = 1'b1;
`else
   localparam bit BM = 1'b0;
`endif

   logic       clk28 = 1'b0;
   logic       rst_n = 1'b0;
   logic       clkcpu_rise = 1'b0;
   logic       cfg_wr = 1'b0;
   logic [2:0] cfg_addr = 3'd0;
   logic [7:0] cfg_d = 8'h00;
   logic [7:0] cfg_q;
   logic       busy, irq;
   logic [3:0] state_dbg;

   zx_dma_master_if bus();

   zx_dma_master #(.RELEASE_GAP(4)) dut (
      .clk28(clk28), .rst_n(rst_n), .clkcpu_rise(clkcpu_rise),
      .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_d(cfg_d), .cfg_q(cfg_q),
      .bus(bus), .busy(busy), .irq(irq), .state_dbg(state_dbg)
   );

   always #5 clk28 = ~clk28;

   int checks = 0;
   int failures = 0;

   logic [7:0]  mem     [0:65535];
   logic [7:0]  ref_mem [0:65535];
   logic [24:0] exp_q[$], obs_wr_q[$];
   logic [16:0] exp_rd_q[$], obs_rd_q[$];

   int ts = 0, strobe_ts = 0, aoe_ts = 0, rd_ts = 0, wr_iorq_ts = 0, wr_mreq_ts = 0;
   int both_ts = 0, nogrant_ts = 0, gap_ts = 0, waitreq_ts = 0, wr_falls = 0, irq_clks = 0;
   int first_ack_ts = -1, first_rd_ts = -1, gcnt = 0, grant_delay = 2, div = 0;
   logic prev_wr = 1'b1, prev_rd = 1'b1;

   function automatic logic [7:0] io_val(input logic [15:0] ad);
      return ad[7:0] ^ ad[15:8] ^ 8'hA5;
   endfunction

   assign bus.d_i = (!bus.n_iorq) ? io_val(bus.a) : mem[bus.a];

   // T-state clock enable, bus monitor and grant responder; monitor samples once per T-state.
   initial bus.n_busack = 1'b1;
   always @(negedge clk28) begin
      if (irq) irq_clks++;
      if (clkcpu_rise) begin
         ts++;
         if (!bus.n_mreq || !bus.n_iorq || !bus.n_rd || !bus.n_wr) strobe_ts++;
         if (bus.a_oe) aoe_ts++;
         if (!bus.n_rd) rd_ts++;
         if (bus.d_oe && !bus.n_iorq) wr_iorq_ts++;
         if (bus.d_oe && !bus.n_mreq) wr_mreq_ts++;
         if (!bus.n_mreq && !bus.n_iorq) both_ts++;
         if (bus.n_busack && (bus.a_oe || !bus.n_mreq || !bus.n_iorq || !bus.n_rd || !bus.n_wr)) nogrant_ts++;
         if (busy && bus.n_busrq) gap_ts++;
         if (!bus.n_busrq && bus.n_busack) waitreq_ts++;
         if (first_ack_ts < 0 && !bus.n_busack && !bus.n_busrq) first_ack_ts = ts;
         if (first_rd_ts < 0 && !bus.n_rd) first_rd_ts = ts;
         if (!bus.n_rd && prev_rd) obs_rd_q.push_back({!bus.n_iorq, bus.a});
         if (!bus.n_wr && prev_wr) begin
            wr_falls++;
            obs_wr_q.push_back({!bus.n_iorq, bus.a, bus.d_o});
            if (!bus.n_mreq) mem[bus.a] = bus.d_o;
         end
         prev_rd = bus.n_rd;
         prev_wr = bus.n_wr;
         if (bus.n_busrq) begin
            gcnt = 0;
            bus.n_busack = 1'b1;
         end else begin
            gcnt++;
            if (gcnt >= grant_delay) bus.n_busack = 1'b0;
         end
      end
      clkcpu_rise = (div == 7);
      div = (div + 1) % 8;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input logic [2:0] ad, input logic [7:0] dv);
      cfg_addr = ad;
      cfg_d    = dv;
      cfg_wr   = 1'b1;
      @(posedge clk28);
      #1;
      cfg_wr = 1'b0;
   endtask

   task automatic cfg_read(input logic [2:0] ad, output logic [7:0] q);
      cfg_addr = ad;
      #1;
      q = cfg_q;
   endtask

   task automatic wait_idle(input string tag);
      bit done = 1'b0;
      for (int k = 0; k < 20000 && !done; k++) begin
         @(negedge clk28);
         #1;
         if (!busy) done = 1'b1;
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      repeat (24) @(negedge clk28);
      #1;
   endtask

   // One transfer: model computes the byte sequence from the register semantics, then the DUT runs it.
   task automatic do_xfer(input string tag, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] l, input logic [4:0] m, input int abort_after, input bit poke);
      int n;
      int i_irq, i_str, i_aoe, i_rd, i_wio, i_wmr, i_both, i_ng, i_gap, w0;
      logic [15:0] sa, da, exp_s, exp_d;
      logic [7:0]  v, lo, hi;
      bit done;
      n = (abort_after > 0) ? abort_after : int'(l);
      cfg_write(3'd0, s[7:0]);
      cfg_write(3'd1, s[15:8]);
      cfg_write(3'd2, d[7:0]);
      cfg_write(3'd3, d[15:8]);
      cfg_write(3'd4, l[7:0]);
      cfg_write(3'd5, l[15:8]);
      cfg_write(3'd6, {3'b000, m});
      exp_q.delete(); exp_rd_q.delete(); obs_wr_q.delete(); obs_rd_q.delete();
      for (int i = 0; i < n; i++) begin
         sa = m[2] ? s : s + 16'(i);
         da = m[3] ? d : d + 16'(i);
         v  = m[0] ? io_val(sa) : ref_mem[sa];
         exp_rd_q.push_back({m[0], sa});
         exp_q.push_back({m[1], da, v});
         if (!m[1]) ref_mem[da] = v;
      end
      exp_s = m[2] ? s : s + 16'(n);
      exp_d = m[3] ? d : d + 16'(n);
      i_irq = irq_clks; i_str = strobe_ts; i_aoe = aoe_ts; i_rd = rd_ts; i_wio = wr_iorq_ts;
      i_wmr = wr_mreq_ts; i_both = both_ts; i_ng = nogrant_ts; i_gap = gap_ts; w0 = wr_falls;
      first_ack_ts = -1;
      first_rd_ts  = -1;
      cfg_write(3'd7, 8'h01);
      if (poke) cfg_write(3'd0, 8'h55);
      if (abort_after > 0) begin
         done = 1'b0;
         for (int k = 0; k < 5000 && !done; k++) begin
            @(negedge clk28);
            #1;
            if (wr_falls == w0 + abort_after) done = 1'b1;
         end
         chk({tag, "_abort_point"}, 32'(done), 32'd1);
         cfg_write(3'd7, 8'h02);
      end
      wait_idle(tag);
      chk({tag, "_nwrites"}, 32'(obs_wr_q.size()), 32'(exp_q.size()));
      while (obs_wr_q.size() > 0 && exp_q.size() > 0)
         chk({tag, "_write"}, 32'(obs_wr_q.pop_front()), 32'(exp_q.pop_front()));
      chk({tag, "_nreads"}, 32'(obs_rd_q.size()), 32'(exp_rd_q.size()));
      while (obs_rd_q.size() > 0 && exp_rd_q.size() > 0)
         chk({tag, "_read"}, 32'(obs_rd_q.pop_front()), 32'(exp_rd_q.pop_front()));
      chk({tag, "_irq"}, 32'(irq_clks - i_irq), (abort_after > 0) ? 32'd0 : 32'd1);
      chk({tag, "_aoe_ts"}, 32'(aoe_ts - i_aoe), 32'(6 * n));
      chk({tag, "_strobe_ts"}, 32'(strobe_ts - i_str), 32'(n * ((m[0] ? 2 : 3) + (m[1] ? 2 : 3))));
      chk({tag, "_rd_ts"}, 32'(rd_ts - i_rd), 32'(n * (m[0] ? 2 : 3)));
      chk({tag, "_wr_iorq_ts"}, 32'(wr_iorq_ts - i_wio), m[1] ? 32'(2 * n) : 32'd0);
      chk({tag, "_wr_mreq_ts"}, 32'(wr_mreq_ts - i_wmr), m[1] ? 32'd0 : 32'(3 * n));
      chk({tag, "_both_req"}, 32'(both_ts - i_both), 32'd0);
      chk({tag, "_nogrant"}, 32'(nogrant_ts - i_ng), 32'd0);
      chk({tag, "_gap_ts"}, 32'(gap_ts - i_gap),
          (BM && m[4] && abort_after == 0) ? 32'(4 * (n - 1)) : 32'd0);
      cfg_read(3'd0, lo); cfg_read(3'd1, hi);
      chk({tag, "_src"}, {16'h0, hi, lo}, {16'h0, exp_s});
      cfg_read(3'd2, lo); cfg_read(3'd3, hi);
      chk({tag, "_dst"}, {16'h0, hi, lo}, {16'h0, exp_d});
      cfg_read(3'd4, lo); cfg_read(3'd5, hi);
      chk({tag, "_len"}, {16'h0, hi, lo}, {16'h0, l - 16'(n)});
      chk({tag, "_busrq_idle"}, 32'(bus.n_busrq), 32'd1);
   endtask

   logic [7:0] rb;
   int w0, i_aoe, i_irq;
   bit done;

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      repeat (5) @(negedge clk28);
      #1;
      chk("rst_busrq", 32'(bus.n_busrq), 32'd1);
      chk("rst_strobes", {28'h0, bus.n_mreq, bus.n_iorq, bus.n_rd, bus.n_wr}, 32'hF);
      chk("rst_oe", {30'h0, bus.a_oe, bus.d_oe}, 32'd0);
      chk("rst_a_d", {8'h0, bus.a, bus.d_o}, 32'd0);
      chk("rst_busy_irq", {30'h0, busy, irq}, 32'd0);
      for (int r = 0; r < 8; r++) begin
         cfg_read(3'(r), rb);
         chk($sformatf("rst_reg%0d", r), 32'(rb), 32'd0);
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk28);
      #1;

      // Mem->mem, three bytes.
      mem[16'h8000] = 8'h11; mem[16'h8001] = 8'h22; mem[16'h8002] = 8'h33;
      ref_mem[16'h8000] = 8'h11; ref_mem[16'h8001] = 8'h22; ref_mem[16'h8002] = 8'h33;
      do_xfer("t1_mem2mem", 16'h8000, 16'hC000, 16'd3, 5'h00, 0, 1'b0);
      chk("t1_c002", 32'(mem[16'hC002]), 32'h33);

      do_xfer("t2_wrap", 16'hFFFF, 16'h4000, 16'd2, 5'h00, 0, 1'b0);

      // Slow grant, with a register write attempted while busy.
      grant_delay = 10;
      i_aoe = waitreq_ts;
      do_xfer("t3_grant", 16'h1234, 16'h5678, 16'd2, 5'h00, 0, 1'b1);
      chk("t3_wait_ts", 32'(waitreq_ts - i_aoe), 32'd10);
      chk("t3_first_rd", 32'(first_rd_ts - first_ack_ts), 32'd0);
      grant_delay = 2;

      do_xfer("t4_mem2io", 16'h9000, 16'h00FE, 16'd4, 5'h0A, 0, 1'b0);

      do_xfer("t5_abort", 16'hA000, 16'hB000, 16'd5, 5'h00, 2, 1'b0);

      // Abort while still waiting for the grant.
      grant_delay = 50;
      i_aoe = aoe_ts; i_irq = irq_clks;
      cfg_write(3'd7, 8'h01);
      repeat (16) @(negedge clk28);
      #1;
      chk("req_abort_busy_before", 32'(busy), 32'd1);
      cfg_write(3'd7, 8'h02);
      chk("req_abort_busy_after", 32'(busy), 32'd0);
      chk("req_abort_busrq", 32'(bus.n_busrq), 32'd1);
      repeat (40) @(negedge clk28);
      #1;
      chk("req_abort_no_cycle", 32'(aoe_ts - i_aoe), 32'd0);
      chk("req_abort_no_irq", 32'(irq_clks - i_irq), 32'd0);
      grant_delay = 2;

      i_aoe = aoe_ts;
      cfg_write(3'd7, 8'h03);
      chk("start_abort_busy", 32'(busy), 32'd0);
      repeat (40) @(negedge clk28);
      #1;
      chk("start_abort_no_cycle", 32'(aoe_ts - i_aoe), 32'd0);

      cfg_write(3'd6, 8'h1F);
      cfg_read(3'd6, rb);
      chk("mode_b4_read", 32'(rb), BM ? 32'h1F : 32'h0F);
      cfg_write(3'd6, 8'h00);
      cfg_read(3'd7, rb);
      chk("ctrl_read_idle", 32'(rb), 32'd0);

`ifdef ZX_DMA_BYTEMODE_EN
      do_xfer("t6_bytemode", 16'h2000, 16'h3000, 16'd2, 5'h10, 0, 1'b0);
`endif

      for (int t = 0; t < 8; t++)
         do_xfer($sformatf("rnd%0d", t), 16'($urandom), 16'($urandom),
                 16'($urandom_range(1, 5)), 5'($urandom_range(0, 15)), 0, 1'b0);

      // Asynchronous reset in the middle of a transfer.
      w0 = wr_falls;
      cfg_write(3'd4, 8'd5);
      cfg_write(3'd7, 8'h01);
      done = 1'b0;
      for (int k = 0; k < 5000 && !done; k++) begin
         @(negedge clk28);
         #1;
         if (wr_falls > w0) done = 1'b1;
      end
      chk("arst_reached", 32'(done), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_busrq", 32'(bus.n_busrq), 32'd1);
      chk("arst_strobes", {28'h0, bus.n_mreq, bus.n_iorq, bus.n_rd, bus.n_wr}, 32'hF);
      chk("arst_oe", {30'h0, bus.a_oe, bus.d_oe}, 32'd0);
      cfg_read(3'd4, rb);
      chk("arst_len", 32'(rb), 32'd0);
      #20;
      rst_n = 1'b1;
      repeat (4) @(negedge clk28);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
